// File: rtl/add64_accum_stage_if.sv
// add64_accum_stage_if: upstream word stream, downstream result and external adder signals.
// slave is the accumulator stage's view; master is the surrounding environment.
interface add64_accum_stage_if #(
  parameter int CNT_W  = 16,
  parameter int BEAT_W = 16
);
  logic              in_valid;
  logic              in_ready;
  logic [63:0]       in_data;
  logic              in_last;
  logic [63:0]       add_a;
  logic [63:0]       add_b;
  logic              add_cin;
  logic [63:0]       add_sum;
  logic              add_cout;
  logic              out_valid;
  logic              out_ready;
  logic [63:0]       out_sum;
  logic [CNT_W-1:0]  out_carries;
  logic              out_ovf;
  logic [BEAT_W-1:0] out_beats;
  modport slave (
    input  in_valid, in_data, in_last, add_sum, add_cout, out_ready,
    output in_ready, add_a, add_b, add_cin, out_valid, out_sum, out_carries, out_ovf, out_beats
  );
  modport master (
    output in_valid, in_data, in_last, add_sum, add_cout, out_ready,
    input  in_ready, add_a, add_b, add_cin, out_valid, out_sum, out_carries, out_ovf, out_beats
  );
endinterface

// File: rtl/add64_accum_stage.sv
// add64_accum_stage: reduces each packet of 64-bit words to a sum plus a saturating
// carry-out count, using an external combinational prefix adder.
module add64_accum_stage #(
  parameter int CNT_W  = 16,
  parameter int BEAT_W = 16
) (
  input logic                clk,
  input logic                rst_n,
  add64_accum_stage_if.slave bus
);
  typedef enum logic {ACC, DONE} state_t;
  state_t            state_q;
  logic [63:0]       acc_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [BEAT_W-1:0] beats_q;
  logic              ovf_q;
  // Adder operands are pure wiring so the acc -> adder -> acc loop stays the only critical path
  assign bus.add_a       = acc_q;
  assign bus.add_b       = bus.in_data;
  assign bus.add_cin     = 1'b0;
  assign bus.in_ready    = state_q == ACC;
  assign bus.out_valid   = state_q == DONE;
  assign bus.out_sum     = acc_q;
  assign bus.out_carries = cnt_q;
  assign bus.out_beats   = beats_q;
  assign bus.out_ovf     = ovf_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ACC;
      acc_q   <= '0;
      cnt_q   <= '0;
      beats_q <= '0;
      ovf_q   <= 1'b0;
    end else if (state_q == ACC) begin
      if (bus.in_valid) begin
        acc_q   <= bus.add_sum;
        cnt_q   <= (bus.add_cout && !(&cnt_q)) ? cnt_q + CNT_W'(1) : cnt_q;
        beats_q <= beats_q + BEAT_W'(1);
        ovf_q   <= ovf_q || (bus.add_cout && &cnt_q) || &beats_q;
        state_q <= bus.in_last ? DONE : ACC;
      end
    end else if (bus.out_ready) begin
      acc_q   <= '0;
      cnt_q   <= '0;
      beats_q <= '0;
      ovf_q   <= 1'b0;
      state_q <= ACC;
    end
  end
endmodule
